// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// Pipeline register with enable and synchronous clear; clear wins over enable.
module ifid_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request FSM, one-entry hold buffer and IF/ID register.
// Handshake: imem_req stays high with a stable imem_addr until a one-cycle imem_ack arrives.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               PCSrc,
  input  logic [N-1:0]       PCBranch,
  output logic               imem_req,
  output logic [N-1:0]       imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_D,
  output logic [N-1:0]       pc_D,
  output logic               valid_D,
  output fetch_state_t       dbg_state
);

  fetch_state_t        state_q, state_d;
  logic [N-1:0]        pc_q, pc_d;
  logic [N-1:0]        req_addr_q, req_addr_d;
  logic                hold_valid_q, hold_valid_d;
  logic [INSTR_W-1:0]  hold_instr_q, hold_instr_d;
  logic [N-1:0]        hold_pc_q, hold_pc_d;

  logic issue;
  logic ack_accept;
  logic ack_direct;
  logic ifid_load;
  logic [INSTR_W+N-1:0] ifid_data_d;
  logic [INSTR_W+N-1:0] ifid_data_q;

  // Only IDLE may start a request, and never while the hold buffer is occupied.
  assign issue      = (state_q == IDLE) && !PCSrc && !hold_valid_q;
  assign ack_accept = (state_q == WAIT) && imem_ack && !PCSrc;
  assign ack_direct = ack_accept && !stall && !hold_valid_q;

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (issue) state_d = WAIT;
      end
      WAIT: begin
        if (PCSrc) state_d = imem_ack ? IDLE : DROP;
        else if (imem_ack) state_d = IDLE;
      end
      DROP: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    imem_req  = (state_q == WAIT) || (state_q == DROP);
    imem_addr = req_addr_q;
    dbg_state = state_q;
  end

  // PC and request address; a redirect always wins, whatever the state.
  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    if (PCSrc) begin
      pc_d = PCBranch;
    end else if (issue) begin
      req_addr_d = pc_q;
      pc_d       = pc_q + N'(PC_INC);
    end
  end

  // Hold buffer: catches an accepted word that IF/ID cannot take this cycle.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (PCSrc) begin
      hold_valid_d = 1'b0;
    end else if (ack_accept && (stall || hold_valid_q)) begin
      hold_valid_d = 1'b1;
      hold_instr_d = imem_rdata;
      hold_pc_d    = req_addr_q;
    end else if (!stall && hold_valid_q) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      req_addr_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // Buffered word drains ahead of fresh memory data.
  assign ifid_load   = hold_valid_q || ack_direct;
  assign ifid_data_d = hold_valid_q ? {hold_instr_q, hold_pc_q} : {imem_rdata, req_addr_q};

  ifid_reg #(.W(1)) u_ifid_valid (
    .clk   (clk),
    .rst_n (reset),
    .en    (~stall),
    .clr   (PCSrc),
    .d     (ifid_load),
    .q     (valid_D)
  );

  // Payload keeps its last value on bubbles and flushes; only valid_D is cleared.
  ifid_reg #(.W(INSTR_W + N)) u_ifid_data (
    .clk   (clk),
    .rst_n (reset),
    .en    (~stall & ifid_load & ~PCSrc),
    .clr   (1'b0),
    .d     (ifid_data_d),
    .q     (ifid_data_q)
  );

  assign instr_D = ifid_data_q[INSTR_W+N-1:N];
  assign pc_D    = ifid_data_q[N-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with a delivery scoreboard.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int N = 64;
  localparam logic [N-1:0] RESET_PC = '0;

  logic               clk;
  logic               reset;
  logic               stall;
  logic               PCSrc;
  logic [N-1:0]       PCBranch;
  logic               imem_req;
  logic [N-1:0]       imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_D;
  logic [N-1:0]       pc_D;
  logic               valid_D;
  fetch_state_t       dbg_state;

  logic [INSTR_W+N-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  fetch_stage #(.N(N), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .PCSrc      (PCSrc),
    .PCBranch   (PCBranch),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_D    (instr_D),
    .pc_D       (pc_D),
    .valid_D    (valid_D),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; a new IF/ID word is popped from the scoreboard when one lands.
  task automatic step();
    logic s, p, r;
    logic [INSTR_W+N-1:0] exp;
    s = stall;
    p = PCSrc;
    r = reset;
    @(posedge clk);
    #1;
    if (r && !s && !p && valid_D) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: got instr=%h pc=%h, required no delivery", instr_D, pc_D);
      end else begin
        exp = exp_q.pop_front();
        if ({instr_D, pc_D} !== exp) begin
          errors++;
          $display("FAIL scoreboard_data: got instr=%h pc=%h, required instr=%h pc=%h",
                   instr_D, pc_D, exp[INSTR_W+N-1:N], exp[N-1:0]);
        end
      end
    end
  endtask

  // Memory driver: hold the request for some wait cycles, then ack with data.
  task automatic fetch_one(input logic [INSTR_W-1:0] instr, input int waits, input logic [N-1:0] addr);
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== addr) begin
        errors++;
        $display("FAIL req_hold: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, addr);
      end
      if (i < waits) step();
    end
    imem_ack   = 1'b1;
    imem_rdata = instr;
    exp_q.push_back({instr, addr});
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    checks++;
    if (valid_D !== 1'b1) begin
      errors++;
      $display("FAIL deliver_valid: got valid_D=%b, required 1", valid_D);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    stall    = 1'b0;
    PCSrc    = 1'b0;
    PCBranch = '0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0 || valid_D !== 1'b0 || instr_D !== '0 || pc_D !== '0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_values: got req=%b valid=%b instr=%h pc=%h st=%0d, required all zero/IDLE",
               imem_req, valid_D, instr_D, pc_D, dbg_state);
    end
    reset = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_zero_wait();
    fetch_one(32'h8B020020, 0, 64'h0);
    checks++;
    if (instr_D[31:21] !== 11'h458 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL opcode0: got op=%h req=%b, required op=458 req=0", instr_D[31:21], imem_req);
    end
    step();
    fetch_one(32'hF84083E1, 0, 64'h4);
    checks++;
    if (instr_D[31:21] !== 11'h7C2) begin
      errors++;
      $display("FAIL opcode1: got op=%h, required 7c2", instr_D[31:21]);
    end
    step();
    checks++;
    if (valid_D !== 1'b0) begin
      errors++;
      $display("FAIL bubble: got valid_D=%b, required 0", valid_D);
    end
  endtask

  task automatic test_wait_states();
    fetch_one(32'h11111111, 3, 64'h8);
    step();
  endtask

  task automatic test_stall_hold();
    stall      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hB4000040;
    exp_q.push_back({32'hB4000040, 64'hC});
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b0 || instr_D !== 32'h11111111 || pc_D !== 64'h8) begin
        errors++;
        $display("FAIL stall_freeze: got req=%b instr=%h pc=%h, required req=0 instr=11111111 pc=8",
                 imem_req, instr_D, pc_D);
      end
      step();
    end
    stall = 1'b0;
    step();
    checks++;
    if (valid_D !== 1'b1 || instr_D !== 32'hB4000040 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL hold_drain: got valid=%b instr=%h req=%b, required 1 b4000040 0", valid_D, instr_D, imem_req);
    end
    step();
    checks++;
    if (valid_D !== 1'b0 || exp_q.size() != 0 || imem_addr !== 64'h10) begin
      errors++;
      $display("FAIL hold_once: got valid=%b pending=%0d addr=%h, required 0 0 10", valid_D, exp_q.size(), imem_addr);
    end
  endtask

  task automatic test_redirect();
    PCSrc    = 1'b1;
    PCBranch = 64'h40;
    step();
    PCSrc = 1'b0;
    checks++;
    if (dbg_state !== DROP || imem_req !== 1'b1 || imem_addr !== 64'h10 || valid_D !== 1'b0) begin
      errors++;
      $display("FAIL drop_state: got st=%0d req=%b addr=%h valid=%b, required DROP 1 10 0",
               dbg_state, imem_req, imem_addr, valid_D);
    end
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    checks++;
    if (valid_D !== 1'b0 || instr_D === 32'hDEADBEEF) begin
      errors++;
      $display("FAIL drop_discard: got valid=%b instr=%h, required valid 0 and no deadbeef", valid_D, instr_D);
    end
    step();
    fetch_one(32'h22222222, 1, 64'h40);
  endtask

  task automatic test_flush_stall();
    stall = 1'b1;
    step();
    checks++;
    if (valid_D !== 1'b1 || imem_addr !== 64'h44 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_issue: got valid=%b req=%b addr=%h, required 1 1 44", valid_D, imem_req, imem_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h33333333;
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    checks++;
    if (valid_D !== 1'b1 || pc_D !== 64'h40 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_capture: got valid=%b pc=%h req=%b, required 1 40 0", valid_D, pc_D, imem_req);
    end
    PCSrc    = 1'b1;
    PCBranch = 64'h100;
    step();
    checks++;
    if (valid_D !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got valid_D=%b, required 0", valid_D);
    end
    PCSrc = 1'b0;
    stall = 1'b0;
    step();
    checks++;
    if (valid_D !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h100) begin
      errors++;
      $display("FAIL flush_hold_cleared: got valid=%b req=%b addr=%h, required 0 1 100", valid_D, imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || valid_D !== 1'b0 || instr_D !== '0 || pc_D !== '0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL async_reset: got req=%b valid=%b instr=%h pc=%h st=%0d, required reset values",
               imem_req, valid_D, instr_D, pc_D, dbg_state);
    end
    exp_q.delete();
    reset = 1'b1;
    step();
    fetch_one(32'h44444444, $urandom_range(0, 2), RESET_PC);
    step();
    checks++;
    if (exp_q.size() != 0 || imem_addr !== 64'h4) begin
      errors++;
      $display("FAIL post_reset: got pending=%0d addr=%h, required 0 4", exp_q.size(), imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_redirect();
    test_flush_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage with IF/ID pipeline register, sitting directly upstream of the main decoder. It owns the program counter and issues requests to instruction memory over a request/acknowledge handshake. It presents the fetched 32-bit instruction to decode; `instr_D[31:21]` drives the decoder `Op` input. It also supports pipeline stall and branch redirect (`PCSrc`/`PCBranch` from the CBZ path).

## Interface
- `N`, 64: address/PC width.
- `RESET_PC`, 0: PC value after reset.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold IF/ID contents. Decode/hazard logic requests a freeze.
- `PCSrc`  in  1  branch taken: redirect fetch and squash younger instructions.
- `PCBranch`  in  N  redirect target, valid when `PCSrc`=1.
- `imem_req`  out  1  request to instruction memory, held high until acknowledged.
- `imem_addr`  out  N  request address, stable while `imem_req`=1.
- `imem_ack`  in  1  single-cycle pulse; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `instr_D`  out  32  IF/ID instruction.
- `pc_D`  out  N  IF/ID instruction address.
- `valid_D`  out  1  IF/ID holds a real instruction. When 0, decode treats the slot as a bubble.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_addr`: address of the outstanding request.
  - `state` ∈ {IDLE, WAIT, DROP}.
  - One-entry hold buffer `{hold_valid, hold_instr, hold_pc}`.
  - IF/ID `{valid_D, instr_D, pc_D}`.
- `imem_req` = (state==WAIT || state==DROP); `imem_addr` = `req_addr`.
- IDLE:
  - If `PCSrc`: `pc`←`PCBranch`, stay IDLE.
  - Else if `hold_valid`=0: `req_addr`←`pc`, `pc`←`pc`+4 (mod 2^N), go to WAIT.
  - Else stay IDLE.
- WAIT:
  - `PCSrc`=1 with `imem_ack`: discard data, `pc`←`PCBranch`, go to IDLE.
  - `PCSrc`=1 without ack: `pc`←`PCBranch`, go to DROP.
  - `imem_ack` without `PCSrc`: data is delivered (see below), go to IDLE.
- DROP:
  - Request stays asserted on the old `req_addr`.
  - On `imem_ack`: data discarded, go to IDLE.
  - `PCSrc` in DROP updates `pc` again (last redirect wins).
- Delivery of acked data (WAIT, no `PCSrc`):
  - If `stall`=0 and `hold_valid`=0: IF/ID←{1, `imem_rdata`, `req_addr`}.
  - Else: hold←{1, `imem_rdata`, `req_addr`}.
- IF/ID update, in priority order:
  1. `PCSrc`=1: `valid_D`←0, `hold_valid`←0.
  2. `stall`=1: IF/ID unchanged.
  3. `hold_valid`=1: IF/ID←hold, `hold_valid`←0.
  4. Accepted ack: IF/ID←ack data.
  5. Otherwise: `valid_D`←0 (bubble); `instr_D`/`pc_D` unchanged.
- `PCSrc` and `stall` together: flush wins.
- The hold buffer never overflows, because no request is issued while `hold_valid`=1.

## Timing
- Reset (asynchronous, active-low) values:
  - `pc`=`RESET_PC`, `req_addr`=0, state=IDLE.
  - `imem_req`=0, `valid_D`=0, `instr_D`=0, `pc_D`=0, `hold_valid`=0.
- Reset mid-request abandons the transaction; memory must tolerate the request dropping.
- First request: `imem_req`=1 in the first cycle after reset deassertion plus one edge (IDLE→WAIT).
- Zero-wait memory (ack in the first WAIT cycle): `valid_D`=1 one edge after the ack. Steady-state throughput is one instruction per 2 cycles.
- Each additional wait cycle adds one cycle of latency.
- `imem_addr` never changes while `imem_req`=1.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum {IDLE, WAIT, DROP}.
  - `INSTR_W`=32.
  - `PC_INC`=4.
- Sub-module `ifid_reg`: parameterized register with enable (`~stall`) and synchronous clear (`PCSrc`), asynchronous active-low reset. Instantiated for the IF/ID pipeline register.
- Top level contains the FSM, PC logic and hold buffer.

## Test plan
- Reset release, memory acks every request immediately, returning instr=0x8B020020 then 0xF84083E1 → `imem_addr` sequence 0, 4; `valid_D` pulses with `pc_D`=0 then 4; `instr_D[31:21]`=0x458 then 0x7C2.
- Ack delayed 3 cycles at address 8 → `imem_addr` stays 8 and `imem_req` stays high for all 3 cycles; `valid_D`=1 one edge after the ack.
- `stall`=1 held for 4 cycles across an ack of 0xB4000040 → IF/ID frozen, hold buffer captures the word, `imem_req`=0 while held; the word appears in `instr_D` the cycle after `stall` drops, with no duplicate and no loss.
- `PCSrc`=1, `PCBranch`=0x40 while WAIT with no ack → state DROP; late ack data never reaches `instr_D`; next request address is 0x40; `valid_D`=0 during the redirect.
- `PCSrc` and `stall` both high with `valid_D`=1 → `valid_D`=0 the next cycle and the hold buffer is cleared.
- Reset asserted during WAIT → all outputs return to reset values asynchronously; the first request after release is to `RESET_PC`.
